// File: rtl/dm_cache_ctrl_pkg.sv
// Shared encodings for the direct-mapped cache controller.
// Holds the cache command codes and the sequencing FSM states.
package dm_cache_ctrl_pkg;

  localparam logic [1:0] CMD_CLR   = 2'b00;
  localparam logic [1:0] CMD_CHECK = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b10;
  localparam logic [1:0] CMD_WRITE = 2'b11;

  typedef enum logic [2:0] {
    ST_FLUSH,
    ST_IDLE,
    ST_CHECK,
    ST_WB,
    ST_FILL,
    ST_REFILL,
    ST_ACCESS,
    ST_DONE
  } state_t;

endpackage

// File: rtl/dmc_ram_port.sv
// RAM handshake holder: keeps one request stable from start until ram_ack is seen.
// The ack only counts while a request is outstanding.
module dmc_ram_port #(
  parameter int RAM_WIDTH  = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  start_we,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [RAM_WIDTH-1:0]  start_wdata,
  input  logic                  ram_ack,
  output logic                  ram_req,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [RAM_WIDTH-1:0]  ram_wdata,
  output logic                  done
);

  assign done = ram_req & ram_ack;

  // A new start wins over a completing transaction so a writeback can chain into a fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_req   <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else if (start) begin
      ram_req  <= 1'b1;
      ram_we   <= start_we;
      ram_addr <= start_addr;
      if (start_we) begin
        ram_wdata <= start_wdata;
      end
    end else if (done) begin
      ram_req <= 1'b0;
      ram_we  <= 1'b0;
    end
  end

endmodule

// File: rtl/dm_cache_ctrl.sv
// Sequencing FSM for a direct-mapped, write-back, one-word-per-line data cache.
// Define DMC_STATS_EN to add saturating hit_count/miss_count outputs.
module dm_cache_ctrl
  import dm_cache_ctrl_pkg::*;
#(
  parameter int RAM_WIDTH       = 8,
  parameter int ADDR_WIDTH      = 8,
  parameter int BLOCK_ADDR_BITS = 4,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [RAM_WIDTH-1:0]  wdata,
  input  logic                  flush,
  output logic                  ready,
  output logic                  ack,
  output logic [RAM_WIDTH-1:0]  rdata,
  output logic [1:0]            cache_cntrl,
  output logic [ADDR_WIDTH-1:0] cache_addr,
  output logic [RAM_WIDTH-1:0]  cache_din,
  input  logic [RAM_WIDTH-1:0]  cache_dout,
  input  logic                  cache_hit,
  input  logic                  cache_clean,
  input  logic [RAM_WIDTH-1:0]  cache_wb_data,
  input  logic [ADDR_WIDTH-1:0] cache_wb_addr,
  output logic                  ram_req,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [RAM_WIDTH-1:0]  ram_wdata,
  input  logic [RAM_WIDTH-1:0]  ram_rdata,
  input  logic                  ram_ack
`ifdef DMC_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count
`endif
);

  if (BLOCK_ADDR_BITS >= ADDR_WIDTH || CNT_WIDTH < 1) begin : g_bad_params
    $error("dm_cache_ctrl: BLOCK_ADDR_BITS must be below ADDR_WIDTH and CNT_WIDTH positive");
  end

  state_t                state, next_state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [RAM_WIDTH-1:0]  wdata_q;
  logic                  accept, start_wb, start_fill, ram_done;
  logic                  ready_n, ack_n;
  logic [1:0]            cntrl_n;
  logic [ADDR_WIDTH-1:0] caddr_n;
  logic [RAM_WIDTH-1:0]  cdin_n;

  assign accept = (state == ST_IDLE) && req;

  // Outputs are computed for the state being entered so every output is a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_FLUSH;
      ready       <= 1'b0;
      ack         <= 1'b0;
      cache_cntrl <= CMD_CLR;
      cache_addr  <= '0;
      cache_din   <= '0;
    end else begin
      state       <= next_state;
      ready       <= ready_n;
      ack         <= ack_n;
      cache_cntrl <= cntrl_n;
      cache_addr  <= caddr_n;
      cache_din   <= cdin_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata   <= '0;
    end else begin
      if (accept) begin
        addr_q  <= addr;
        we_q    <= we;
        wdata_q <= wdata;
      end
      if (state == ST_ACCESS && !we_q) begin
        rdata <= cache_dout;
      end
    end
  end

  always_comb begin
    next_state = state;
    start_wb   = 1'b0;
    start_fill = 1'b0;
    unique case (state)
      ST_FLUSH: next_state = ST_IDLE;
      ST_IDLE: begin
        if (req)        next_state = ST_CHECK;
        else if (flush) next_state = ST_FLUSH;
      end
      ST_CHECK: begin
        if (cache_hit) begin
          next_state = ST_ACCESS;
        end else if (!cache_clean) begin
          next_state = ST_WB;
          start_wb   = 1'b1;
        end else if (we_q) begin
          next_state = ST_ACCESS;
        end else begin
          next_state = ST_FILL;
          start_fill = 1'b1;
        end
      end
      ST_WB: begin
        if (ram_done) begin
          if (we_q) begin
            next_state = ST_ACCESS;
          end else begin
            next_state = ST_FILL;
            start_fill = 1'b1;
          end
        end
      end
      ST_FILL:   if (ram_done) next_state = ST_REFILL;
      ST_REFILL: next_state = ST_ACCESS;
      ST_ACCESS: next_state = ST_DONE;
      ST_DONE:   next_state = ST_IDLE;
      default:   next_state = ST_FLUSH;
    endcase

    ready_n = (next_state == ST_IDLE);
    ack_n   = (next_state == ST_DONE);
    cntrl_n = CMD_CHECK;
    caddr_n = accept ? addr : addr_q;
    cdin_n  = cache_din;
    case (next_state)
      ST_FLUSH: cntrl_n = CMD_CLR;
      ST_REFILL: begin
        cntrl_n = CMD_WRITE;
        cdin_n  = ram_rdata;
      end
      ST_ACCESS: begin
        if (we_q) begin
          cntrl_n = CMD_WRITE;
          cdin_n  = wdata_q;
        end else begin
          cntrl_n = CMD_READ;
        end
      end
      default: ;
    endcase
  end

  dmc_ram_port #(
    .RAM_WIDTH (RAM_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram_port (
    .clk        (clk),
    .rst        (rst),
    .start      (start_wb | start_fill),
    .start_we   (start_wb),
    .start_addr (start_wb ? cache_wb_addr : addr_q),
    .start_wdata(cache_wb_data),
    .ram_ack    (ram_ack),
    .ram_req    (ram_req),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .done       (ram_done)
  );

`ifdef DMC_STATS_EN
  // One count per processor request, taken when the check result is evaluated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == ST_FLUSH) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == ST_CHECK) begin
      if (cache_hit) begin
        if (hit_count != '1) hit_count <= hit_count + CNT_WIDTH'(1);
      end else begin
        if (miss_count != '1) miss_count <= miss_count + CNT_WIDTH'(1);
      end
    end
  end
`endif

endmodule

// File: doc/dm_cache_ctrl.md
Name: dm_cache_ctrl

Overview:
- Sequencing FSM for the direct-mapped, write-back, one-word-per-line data cache.
- Accepts one processor load/store at a time and drives the cache's 2-bit command port: 00 clear, 01 check, 10 read, 11 write.
- On a miss it writes back a dirty victim to RAM, fetches the missing word on a read miss, then completes the access.
- Sits between the processor memory stage and the cache/RAM pair.

Parameters:
- RAM_WIDTH, 8, data word width.
- ADDR_WIDTH, 8, address width.
- BLOCK_ADDR_BITS, 4, index bits (2**BLOCK_ADDR_BITS lines).
- CNT_WIDTH, 16, statistics counter width (used only with the optional feature).

Ports:
- clk  in  1  system clock; controller acts on posedge, cache acts on negedge.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  processor request; sampled only when ready=1.
- we  in  1  1=store, 0=load.
- addr  in  ADDR_WIDTH  processor address.
- wdata  in  RAM_WIDTH  store data.
- flush  in  1  clear whole cache; sampled in IDLE, req takes priority.
- ready  out  1  FSM in IDLE.
- ack  out  1  one-cycle completion pulse.
- rdata  out  RAM_WIDTH  load result, valid with ack, held until next ack.
- cache_cntrl  out  2  cache command.
- cache_addr  out  ADDR_WIDTH  cache address.
- cache_din  out  RAM_WIDTH  cache write data.
- cache_dout  in  RAM_WIDTH  cache read data.
- cache_hit  in  1  tag match from check.
- cache_clean  in  1  victim not dirty, from check.
- cache_wb_data  in  RAM_WIDTH  victim data.
- cache_wb_addr  in  ADDR_WIDTH  victim address.
- ram_req  out  1  RAM transaction request.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_wdata  out  RAM_WIDTH  RAM write data.
- ram_rdata  in  RAM_WIDTH  RAM read data.
- ram_ack  in  1  RAM completion.

Behaviour:
- States: FLUSH, IDLE, CHECK, WB, FILL, REFILL, ACCESS, DONE. All outputs are registered.
- Reset values: state=FLUSH, ready=0, ack=0, rdata=0, cache_cntrl=00, cache_addr=0, cache_din=0, ram_req=0, ram_we=0, ram_addr=0, ram_wdata=0.
- FLUSH: cache_cntrl=00 for exactly 1 cycle, then IDLE. CLR discards dirty lines; there is no writeback.
- IDLE: ready=1, cache_cntrl=01 (never 00 or 11 while idle); cache_addr tracks the latched address.
- IDLE with req=1: latch addr/we/wdata, go to CHECK. With req=0 and flush=1: go to FLUSH.
- CHECK: cache_cntrl=01. The cache samples on the mid-cycle negedge; at the closing posedge the FSM evaluates cache_hit/cache_clean/cache_wb_*:
  - hit -> ACCESS
  - miss and dirty -> WB (latch cache_wb_addr/cache_wb_data into ram_addr/ram_wdata)
  - miss, clean, store -> ACCESS (one-word lines need no fill)
  - miss, clean, load -> FILL
- WB: ram_req=1, ram_we=1, held stable until ram_ack is sampled high. Then load -> FILL, store -> ACCESS. ram_req drops the cycle after ack.
- FILL: ram_req=1, ram_we=0, ram_addr=latched addr. On ram_ack, capture ram_rdata and go to REFILL.
- REFILL: cache_cntrl=11, cache_din=fill data, then ACCESS. The filled line is marked dirty by the cache; this is accepted as conservative behaviour.
- ACCESS: cache_cntrl=10 (load) or 11 (store, cache_din=wdata), 1 cycle; load captures cache_dout at the closing posedge. Then DONE.
- DONE: ack=1, rdata updated for loads, cache_cntrl=01, then IDLE.
- Latency from accepting req: hit = 3 cycles to ack (CHECK, ACCESS, DONE). Misses add the RAM wait cycles plus 1 for REFILL.
- ram_ack while ram_req=0 is ignored. req while ready=0 is ignored and must be held by the requester.
- Reset mid-operation: all outputs return to reset values immediately (ram_req drops asynchronously); any pending RAM transaction is abandoned; FLUSH reruns.

Optional Feature:
- DMC_STATS_EN defined: add outputs hit_count and miss_count (CNT_WIDTH each).
  - Each increments by 1 at the CHECK evaluation of a processor request.
  - Both saturate at all-ones, clear on rst and on FLUSH.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package: cache command encodings (CMD_CLR=2'b00, CMD_CHECK=2'b01, CMD_READ=2'b10, CMD_WRITE=2'b11) and the FSM state encoding.
- One natural sub-module: dmc_ram_port, the ram_req/ram_ack handshake holder used by WB and FILL.

Test Plan:
- Reset release -> cache_cntrl=00 for exactly 1 cycle, then 01; ready=1 on the next cycle.
- Store addr=0x35, wdata=0xA5 after flush (clean miss) -> no ram_req; one cycle of cache_cntrl=11 with cache_din=0xA5; ack 3 cycles after acceptance.
- Load addr=0x35 -> hit; rdata=0xA5 with ack at cycle 3; ram_req stays 0.
- Load addr=0x45 (dirty victim at line 5) -> RAM write addr=0x35 data=0xA5; then RAM read addr=0x45; RAM returns 0x3C after 2 wait cycles -> rdata=0x3C; a following load of 0x45 hits.
- rst asserted while ram_req=1 in FILL -> ram_req=0 immediately; FLUSH then IDLE; no ack emitted.
- With DMC_STATS_EN: the sequence above -> hit_count=2, miss_count=2; forced counter at all-ones stays saturated.
